note_sequencer: RTL and testbench

Pattern-driven melody source placed directly upstream of the PWM audio generator. Stores a short programmable sequence of notes (frequency code + duration) and, once started, steps through it at a fixed tempo. It drives the 8-bit frequency word that the PWM stage converts into an audio square wave. A frequency code of 0 is a rest; the PWM stage treats it as silence.

---
 rtl/note_sequencer_if.sv | 33 +++
 rtl/note_sequencer.sv | 160 ++++++++++++++++
 tb/tb_note_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: pattern-load and playback bus of the note sequencer.
//   master (controller/bench) drives pattern writes and playback control;
//   slave (note_sequencer) returns the frequency word and status pulses.
//   wr_en/wr_addr/wr_data : pattern entry write {dur[11:8], freq[7:0]}
//   len/loop/start/stop    : playback control
//   frequency/note_strobe/busy/done : playback outputs
interface note_sequencer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [AW:0]   len;
  logic          loop;
  logic          start;
  logic          stop;
  logic [7:0]    frequency;
  logic          note_strobe;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, len, loop, start, stop,
    input  frequency, note_strobe, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, loop, start, stop,
    output frequency, note_strobe, busy, done
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: programmable melody source feeding the PWM audio stage.
// Stores DEPTH entries of {dur, freq}; on start steps through len of them,
// each held for dur tempo ticks (dur 0 = 16 ticks) of TICK_DIV clocks.
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : note_sequencer_if slave (pattern write, control, outputs)
// All outputs are registered.
module note_sequencer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TICK_DIV = 25000
) (
  input  logic           clk,
  input  logic           reset,
  note_sequencer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef struct packed {
    logic [3:0] dur;
    logic [7:0] freq;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic [AW-1:0] last, last_n;
  logic          loop_r, loop_n;
  logic [4:0]    dur_cnt, dur_n;
  logic [PW-1:0] presc, presc_n;
  logic [7:0]    freq_q, freq_n;
  logic          strobe_q, strobe_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;

  entry_t        mem [DEPTH];
  entry_t        cur;
  logic [AW:0]   len_clamped;
  logic          tick;

  // Pattern memory: not reset, writable in every state.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= entry_t'(bus.wr_data);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      last     <= '0;
      loop_r   <= 1'b0;
      dur_cnt  <= '0;
      presc    <= '0;
      freq_q   <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      last     <= last_n;
      loop_r   <= loop_n;
      dur_cnt  <= dur_n;
      presc    <= presc_n;
      freq_q   <= freq_n;
      strobe_q <= strobe_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    last_n   = last;
    loop_n   = loop_r;
    dur_n    = dur_cnt;
    presc_n  = presc;
    freq_n   = freq_q;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    busy_n   = 1'b0;

    cur         = mem[ptr];
    len_clamped = (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;
    tick        = (presc == PW'(TICK_DIV - 1));

    case (state)
      IDLE: begin
        freq_n = 8'h00;
        if (bus.start && !bus.stop && (bus.len != '0)) begin
          ptr_n   = '0;
          last_n  = AW'(len_clamped - (AW+1)'(1));
          loop_n  = bus.loop;
          state_n = FETCH;
        end
      end

      FETCH: begin
        if (bus.stop) begin
          freq_n  = 8'h00;
          state_n = IDLE;
        end else begin
          freq_n   = cur.freq;
          dur_n    = (cur.dur == 4'd0) ? 5'd16 : {1'b0, cur.dur};
          presc_n  = '0;
          strobe_n = 1'b1;
          state_n  = HOLD;
        end
      end

      HOLD: begin
        if (bus.stop) begin
          freq_n  = 8'h00;
          state_n = IDLE;
        end else begin
          presc_n = tick ? '0 : PW'(presc + PW'(1));
          if (tick) begin
            dur_n = dur_cnt - 5'd1;
            // Last tick of the note: advance, wrap, or finish.
            if (dur_cnt == 5'd1) begin
              if (ptr != last) begin
                ptr_n   = ptr + AW'(1);
                state_n = FETCH;
              end else if (loop_r) begin
                ptr_n   = '0;
                state_n = FETCH;
              end else begin
                freq_n  = 8'h00;
                done_n  = 1'b1;
                state_n = IDLE;
              end
            end
          end
        end
      end

      default: begin
        freq_n  = 8'h00;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.frequency   = freq_q;
  assign bus.note_strobe = strobe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed and randomized playback checks of note_sequencer
// against a note-timeline model (TICK_DIV=4, DEPTH=16).
module tb_note_sequencer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TICK  = 4;

  logic clk;
  logic reset;

  note_sequencer_if #(.DEPTH(DEPTH)) bus ();

  note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TICK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [11:0] model_mem [DEPTH];
  // Expected per-cycle {frequency, note_strobe, busy, done}.
  logic [10:0] exp_q [$];

  function automatic logic [10:0] obs_vec();
    return {bus.frequency, bus.note_strobe, bus.busy, bus.done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic write_entry(input int addr, input logic [11:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(addr);
    bus.wr_data = data;
    model_mem[addr] = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Timeline model: one FETCH cycle, then dur*TICK cycles showing the note;
  // the previous note stays on the output through each FETCH cycle.
  function automatic void build_exp(input int n_len, input bit lp, input int max_cyc);
    int n;
    int idx;
    int ticks;
    logic [7:0] f;
    exp_q.delete();
    n   = (n_len > DEPTH) ? DEPTH : n_len;
    idx = 0;
    exp_q.push_back({8'h00, 1'b0, 1'b1, 1'b0});
    while (exp_q.size() < max_cyc) begin
      f     = model_mem[idx][7:0];
      ticks = (model_mem[idx][11:8] == 4'd0) ? 16 : int'(model_mem[idx][11:8]);
      for (int j = 0; j < ticks * TICK; j++) exp_q.push_back({f, (j == 0), 1'b1, 1'b0});
      if ((idx == n - 1) && !lp) begin
        exp_q.push_back({8'h00, 1'b0, 1'b0, 1'b1});
        exp_q.push_back({8'h00, 1'b0, 1'b0, 1'b0});
        break;
      end
      idx = (idx == n - 1) ? 0 : idx + 1;
      exp_q.push_back({f, 1'b0, 1'b1, 1'b0});
    end
  endfunction

  // Pulse start and compare every following cycle to the model timeline.
  task automatic run_exp(input string tag, input int n_len, input bit lp);
    @(negedge clk);
    bus.len   = 5'(n_len);
    bus.loop  = lp;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("%s[%0d]", tag, i), 32'(obs_vec()), 32'(exp_q[i]));
    end
  endtask

  initial begin
    int found;
    int n;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_outputs", 32'(obs_vec()), 32'h0);

    // Single pass, directed.
    write_entry(0, 12'h240);
    write_entry(1, 12'h180);
    write_entry(2, 12'h300);
    build_exp(3, 1'b0, 10000);
    run_exp("single", 3, 1'b0);

    // Loop with 16-tick note, then stop.
    write_entry(0, 12'h011);
    write_entry(1, 12'h122);
    build_exp(2, 1'b1, 160);
    run_exp("loop", 2, 1'b1);
    @(negedge clk);
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    check("loop_stop", 32'({bus.frequency, bus.busy}), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("loop_stop_idle", 32'(obs_vec()), 32'h0);

    // len=0 start is ignored.
    @(negedge clk);
    bus.len = '0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("len0_idle", 32'(obs_vec()), 32'h0);

    // start and stop together from IDLE.
    bus.len = 5'd2;
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    @(posedge clk); #1;
    check("start_stop_idle", 32'(obs_vec()), 32'h0);

    // len=20 clamps to 16 entries.
    for (int a = 0; a < DEPTH; a++) write_entry(a, {4'd1, 8'($urandom_range(0, 255))});
    build_exp(20, 1'b0, 10000);
    run_exp("clamp", 20, 1'b0);

    // Randomized patterns and lengths.
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < DEPTH; a++)
        write_entry(a, {4'($urandom_range(0, 4)), 8'($urandom_range(0, 255))});
      n = $urandom_range(1, 20);
      build_exp(n, 1'b0, 10000);
      run_exp($sformatf("rand%0d", it), n, 1'b0);
    end

    // Live write of an entry not yet fetched.
    write_entry(0, 12'h233);
    write_entry(1, 12'h366);
    @(negedge clk);
    bus.len = 5'd2; bus.loop = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    write_entry(1, 12'h155);
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.note_strobe) begin
        found = 1;
        break;
      end
    end
    check("live_strobe_seen", 32'(found), 32'd1);
    check("live_freq", 32'(bus.frequency), 32'h55);
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (!bus.busy) begin
        found = 1;
        break;
      end
    end
    check("live_finish", 32'(found), 32'd1);

    // Back-to-back: start held, next run's strobe 2 cycles after done.
    write_entry(0, 12'h177);
    @(negedge clk);
    bus.len = 5'd1; bus.loop = 1'b0; bus.start = 1'b1;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        found = 1;
        break;
      end
    end
    check("b2b_done_seen", 32'(found), 32'd1);
    check("b2b_done_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("b2b_restart_busy", 32'({bus.note_strobe, bus.busy}), 32'h1);
    @(posedge clk); #1;
    check("b2b_strobe", 32'({bus.frequency, bus.note_strobe}), 32'h0EF);
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("b2b_end_idle", 32'(obs_vec()), 32'h0);

    // Asynchronous reset in the middle of HOLD.
    write_entry(0, 12'h0A5);
    @(negedge clk);
    bus.len = 5'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_playing", 32'({bus.frequency, bus.busy}), 32'h14B);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset", 32'(obs_vec()), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(obs_vec()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
